maquina_receptor_mesi: RTL

Clocked, multi-line snoop-side coherence controller. Successor of the single-line combinational MSI receptor. Holds a direct-mapped state/tag array of NUM_LINES lines and implements MESI. Accepts bus messages through a valid/ready handshake and sequences write-back with an acknowledge instead of fixed delays. Sits between the shared snoop bus and the local cache controller (emitter machine).

---
 rtl/maquina_receptor_mesi.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/maquina_receptor_mesi.sv
// ============================================================================
// Module     : maquina_receptor_mesi
// Description: Snoop-side MESI coherence controller with a direct-mapped
//              state/tag array, a valid/ready snoop port and acknowledged
//              write-back sequencing. Optional macro SNOOP_STATS_EN adds
//              saturating hit / write-back counters.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module maquina_receptor_mesi #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               snoop_valid,
    output logic               snoop_ready,
    input  logic [1:0]         snoop_msg,
    input  logic [INDEX_W-1:0] snoop_index,
    input  logic [TAG_W-1:0]   snoop_tag,
    input  logic               loc_valid,
    output logic               loc_ready,
    input  logic [INDEX_W-1:0] loc_index,
    input  logic [TAG_W-1:0]   loc_tag,
    input  logic [1:0]         loc_state,
    output logic               wb_req,
    output logic [INDEX_W-1:0] wb_index,
    input  logic               wb_ack,
    output logic               abort_mem,
    output logic               resp_valid,
    output logic               resp_shared,
    output logic               proto_err,
    input  logic [INDEX_W-1:0] probe_index,
`ifdef SNOOP_STATS_EN
    output logic [15:0]        stat_hits,
    output logic [15:0]        stat_wbs,
`endif
    output logic [1:0]         probe_state
);

    localparam int NUM_LINES = 2 ** INDEX_W;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_M = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;

    localparam logic [1:0] MSG_INV  = 2'b00;
    localparam logic [1:0] MSG_RD   = 2'b01;
    localparam logic [1:0] MSG_NONE = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] WB    = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]         fsm_state;
    logic [1:0]         fsm_next;
    logic [1:0]         state_arr [NUM_LINES];
    logic [TAG_W-1:0]   tag_arr   [NUM_LINES];
    logic [1:0]         pend_msg;
    logic [INDEX_W-1:0] pend_index;
    logic [TAG_W-1:0]   pend_tag;
    logic               shared_q;

    logic               accept;
    logic               hit;
    logic [1:0]         line_state;
    logic               commit_en;
    logic               shared_en;
    logic               shared_val;
    logic [1:0]         snoop_new_state;

    assign line_state      = state_arr[pend_index];
    assign hit             = (line_state != ST_I) && (tag_arr[pend_index] == pend_tag);
    assign snoop_new_state = (pend_msg == MSG_RD) ? ST_S : ST_I;
    assign accept          = snoop_valid && snoop_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_state <= IDLE;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_state;
        commit_en  = 1'b0;
        shared_en  = 1'b0;
        shared_val = 1'b0;
        case (fsm_state)
            IDLE: begin
                if (accept && snoop_msg != MSG_NONE) begin
                    fsm_next = CHECK;
                end
            end
            CHECK: begin
                if (!hit) begin
                    shared_en = 1'b1;
                    fsm_next  = RESP;
                end else if (line_state == ST_M) begin
                    fsm_next = WB;
                end else begin
                    commit_en  = 1'b1;
                    shared_en  = 1'b1;
                    shared_val = (pend_msg == MSG_RD);
                    fsm_next   = RESP;
                end
            end
            WB: begin
                if (wb_ack) begin
                    commit_en  = 1'b1;
                    shared_en  = 1'b1;
                    shared_val = (pend_msg == MSG_RD);
                    fsm_next   = RESP;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_comb begin
        snoop_ready = (fsm_state == IDLE) && !(loc_valid && loc_index == snoop_index);
        loc_ready   = !((fsm_state != IDLE) && (loc_index == pend_index));
        wb_req      = (fsm_state == WB);
        abort_mem   = (fsm_state == WB);
        wb_index    = pend_index;
        resp_valid  = (fsm_state == RESP);
        resp_shared = (fsm_state == RESP) && shared_q;
        proto_err   = (fsm_state == CHECK) && hit && (line_state == ST_M) && (pend_msg == MSG_INV);
        probe_state = state_arr[probe_index];
    end

    // Local updates and snoop commits never collide: loc_ready blocks the pending index.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_arr[i] <= ST_I;
                tag_arr[i]   <= '0;
            end
            pend_msg   <= MSG_NONE;
            pend_index <= '0;
            pend_tag   <= '0;
            shared_q   <= 1'b0;
        end else begin
            if (loc_valid && loc_ready) begin
                state_arr[loc_index] <= loc_state;
                tag_arr[loc_index]   <= loc_tag;
            end
            if (accept) begin
                pend_msg   <= snoop_msg;
                pend_index <= snoop_index;
                pend_tag   <= snoop_tag;
            end
            if (commit_en) begin
                state_arr[pend_index] <= snoop_new_state;
            end
            if (shared_en) begin
                shared_q <= shared_val;
            end
        end
    end

`ifdef SNOOP_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_hits <= '0;
            stat_wbs  <= '0;
        end else begin
            if (fsm_state == CHECK && hit && stat_hits != 16'hFFFF) begin
                stat_hits <= stat_hits + 16'd1;
            end
            if (fsm_state == WB && wb_ack && stat_wbs != 16'hFFFF) begin
                stat_wbs <= stat_wbs + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
